omem_readback: RTL and testbench
================================

# omem_readback

Host-side readback engine for the THEIA output memories. It drives the output-bank select and address inputs and captures the returned pixel words. After the cores signal completion, it streams every word of every core bank to the host over a valid/ready interface. It is the reader at the far end of the OMBSEL/OMADR/OMEM port, sitting between the THEIA top and the host frame sink.

## Interface
- WB_WIDTH, 32, data and address width; matches the THEIA OMEM and OMADR buses.
- CORE_BITS, 2, width of the bank select; the number of banks NBANKS = 2^CORE_BITS.
- CNT_W, 18, width of the per-bank word count; covers a 250000-word bank.

- CLK_I  in  1  single clock; all logic is on the rising edge.
- RST_I  in  1  synchronous, active-low reset.
- START_I  in  1  one-cycle request to begin a readback; sampled only in IDLE.
- COUNT_I  in  CNT_W  words per bank to read; latched on an accepted START_I.
- DONE_I  in  1  THEIA DONE_O, meaning all cores have finished rendering.
- OMBSEL_O  out  CORE_BITS  bank select driven to THEIA OMBSEL_I.
- OMADR_O  out  WB_WIDTH  word address within the bank, driven to THEIA OMADR_I; bits above CNT_W are zero.
- OMEM_I  in  WB_WIDTH  THEIA OMEM_O; valid exactly 1 cycle after the OMBSEL_O/OMADR_O pair it answers.
- DAT_O  out  WB_WIDTH  output word.
- VLD_O  out  1  DAT_O is valid.
- RDY_I  in  1  host accepts DAT_O; a transfer occurs when VLD_O and RDY_I are both high.
- LAST_O  out  1  qualifies the final word of the readback; meaningful only while VLD_O is high.
- BUSY_O  out  1  a readback is in progress.
- FINISH_O  out  1  one-cycle pulse after the final word is transferred.

## Operation
- **States:** IDLE, WAIT_DONE, READ, DRAIN, FIN.
- **IDLE:**
  - START_I moves to WAIT_DONE and latches COUNT_I into cnt_q.
  - The bank counter and word counter are cleared.
- **WAIT_DONE:** holds until DONE_I=1.
  - If cnt_q=0, go to FIN.
  - Otherwise go to READ.
- **READ:**
  - One read is issued per cycle when the issue condition holds: fifo_cnt + inflight − pop < 2.
    - pop = VLD_O & RDY_I.
    - inflight = a read was issued in the previous cycle.
  - **Address order:** the word counter runs 0..cnt_q−1, then wraps to 0 and the bank counter increments.
  - The bank is the outer loop and runs 0..NBANKS−1.
  - When the issue is for word cnt_q−1 of bank NBANKS−1, go to DRAIN.
  - A last flag travels with that read.
- **Return path:** OMEM_I is written into a 2-entry FIFO on the cycle after each issue, together with the last flag.
  - Because of the issue rule, the FIFO never overflows.
  - DAT_O, VLD_O and LAST_O come from the FIFO head.
- **DRAIN:**
  - No further issues.
  - When the FIFO is empty and inflight=0, go to FIN.
- **FIN:** FINISH_O=1 for exactly one cycle, then IDLE.
- **BUSY_O** is high in WAIT_DONE, READ, DRAIN and FIN.
- **Ignored inputs:**
  - START_I outside IDLE.
  - DONE_I outside WAIT_DONE.
  - A DONE_I drop during READ does not abort the readback.
- **Address hold:** OMBSEL_O/OMADR_O hold their last value when no issue is made. Data is captured only for issued cycles.

## Timing
- **Reset (RST_I=0 at an edge):** all state returns to IDLE on the next cycle.
  - VLD_O=0, LAST_O=0, BUSY_O=0, FINISH_O=0, OMBSEL_O=0, OMADR_O=0, DAT_O=0.
  - The FIFO is emptied and inflight is cleared.
  - Reset mid-readback discards all pending words, with no FINISH_O.
- **Start sequence:** START_I at cycle t gives BUSY_O=1 at t+1.
- **First read:** if DONE_I is already high at t+1, READ is entered at t+2 and the first address appears at t+2.
- **Read latency:** address issued at cycle n → FIFO write at the n+1 edge → VLD_O=1 at n+2.
- **Throughput:** with RDY_I held at 1, one word per cycle.
  - Total words = NBANKS·cnt_q.
  - The final word is transferred at cycle t+3+NBANKS·cnt_q.
  - FINISH_O follows on the next cycle and IDLE on the cycle after that.
- **Back-pressure:** with RDY_I=0, at most 2 words are buffered and issuing stops.
  - Word order and values are preserved exactly.
  - VLD_O stays high and DAT_O stays stable until the transfer.
- **Simultaneous write and pop:** a FIFO write and a pop in the same cycle keep the count unchanged.
- **Zero count:** with cnt_q=0, no reads are issued and VLD_O never rises. FINISH_O pulses one cycle after DONE_I is seen.

## Test plan
- **Basic readback:** banks preloaded with bank b word w = {b,w}; COUNT_I=3, DONE_I=1, RDY_I=1.
  - 12 words in order {0,0},{0,1},{0,2},{1,0}…{3,2}, one per cycle.
  - LAST_O only on {3,2}; FINISH_O on the following cycle.
- **Random back-pressure:** RDY_I random at 50%, COUNT_I=5.
  - All 20 words in order, with no duplicates or losses.
  - DAT_O stable while VLD_O=1 and RDY_I=0.
  - OMADR_O never advances more than 2 ahead of the transferred word.
- **Wait for DONE:** START_I with DONE_I=0 for 10 cycles.
  - No address change and VLD_O=0 while waiting.
  - The first read is issued the cycle after DONE_I rises.
- **Zero count:** COUNT_I=0.
  - VLD_O never asserts.
  - FINISH_O is a single pulse 2 cycles after START_I when DONE_I=1.
- **Reset mid-readback:** RST_I=0 for 1 cycle after 6 of 12 words.
  - Next cycle: VLD_O=0, BUSY_O=0, no FINISH_O.
  - A new START_I restarts at bank 0, word 0.
- **START while busy:** START_I with COUNT_I=7 during READ of a COUNT_I=3 job.
  - The request is ignored; exactly 12 words are produced.

Source files
------------

// File: rtl/omem_readback_if.sv
// Bus bundle for the readback engine: OMEM read port toward THEIA and the
// valid/ready word stream toward the host frame sink.
interface omem_readback_if #(
  parameter int unsigned WB_WIDTH  = 32,
  parameter int unsigned CORE_BITS = 2
);
  logic [CORE_BITS-1:0] OMBSEL_O;
  logic [WB_WIDTH-1:0]  OMADR_O;
  logic [WB_WIDTH-1:0]  OMEM_I;
  logic [WB_WIDTH-1:0]  DAT_O;
  logic                 VLD_O;
  logic                 RDY_I;
  logic                 LAST_O;

  modport master (
    output OMBSEL_O, OMADR_O, DAT_O, VLD_O, LAST_O,
    input  OMEM_I, RDY_I
  );

  modport slave (
    input  OMBSEL_O, OMADR_O, DAT_O, VLD_O, LAST_O,
    output OMEM_I, RDY_I
  );
endinterface

// File: rtl/omem_readback.sv
// Host-side readback engine: walks every word of every THEIA output bank and
// streams the returned pixel words to the host through a 2-entry return FIFO.
module omem_readback #(
  parameter int unsigned WB_WIDTH  = 32,
  parameter int unsigned CORE_BITS = 2,
  parameter int unsigned CNT_W     = 18
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             START_I,
  input  logic [CNT_W-1:0] COUNT_I,
  input  logic             DONE_I,
  output logic             BUSY_O,
  output logic             FINISH_O,
  omem_readback_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_DONE, S_READ, S_DRAIN, S_FIN
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     word_q, word_d;
  logic [CORE_BITS-1:0] bank_q, bank_d;
  logic                 inflight_q, inflight_d;
  logic                 infl_last_q, infl_last_d;
  logic [WB_WIDTH-1:0]  fdat_q [2];
  logic [WB_WIDTH-1:0]  fdat_d [2];
  logic [1:0]           flast_q, flast_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           fcnt_q, fcnt_d;
  logic                 busy_q, busy_d;
  logic                 finish_q, finish_d;

  logic vld_c, pop_c, issue_c, at_last_c;

  // FIFO head drives the host stream; the counters are the read address.
  assign vld_c        = (fcnt_q != 2'd0);
  assign pop_c        = vld_c & bus.RDY_I;
  assign bus.VLD_O    = vld_c;
  assign bus.DAT_O    = fdat_q[rd_ptr_q];
  assign bus.LAST_O   = vld_c & flast_q[rd_ptr_q];
  assign bus.OMBSEL_O = bank_q;
  assign bus.OMADR_O  = WB_WIDTH'(word_q);
  assign BUSY_O       = busy_q;
  assign FINISH_O     = finish_q;

  // Issue only while buffered + returning words, net of this cycle's pop, leave room.
  assign issue_c   = (state_q == S_READ) &&
                     ((3'(fcnt_q) + 3'(inflight_q) - 3'(pop_c)) < 3'd2);
  assign at_last_c = (word_q == cnt_q - CNT_W'(1)) && (bank_q == {CORE_BITS{1'b1}});

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    bank_d      = bank_q;
    inflight_d  = issue_c;
    infl_last_d = issue_c & at_last_c;
    fdat_d      = fdat_q;
    flast_d     = flast_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fcnt_d      = fcnt_q + 2'(inflight_q) - 2'(pop_c);

    // Word returned one cycle after its address lands in the FIFO.
    if (inflight_q) begin
      fdat_d[wr_ptr_q]  = bus.OMEM_I;
      flast_d[wr_ptr_q] = infl_last_q;
      wr_ptr_d          = ~wr_ptr_q;
    end
    if (pop_c) rd_ptr_d = ~rd_ptr_q;

    unique case (state_q)
      S_IDLE: begin
        word_d = '0;
        bank_d = '0;
        if (START_I) begin
          cnt_d   = COUNT_I;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (DONE_I) state_d = (cnt_q == '0) ? S_FIN : S_READ;
      end
      S_READ: begin
        if (issue_c) begin
          if (at_last_c) begin
            state_d = S_DRAIN;
          end else if (word_q == cnt_q - CNT_W'(1)) begin
            word_d = '0;
            bank_d = bank_q + CORE_BITS'(1);
          end else begin
            word_d = word_q + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        // Leave as the final word is popped so FINISH follows it directly.
        if (!inflight_q && (fcnt_q == 2'd0 || (fcnt_q == 2'd1 && pop_c)))
          state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d != S_IDLE);
    finish_d = (state_d == S_FIN);
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      bank_q      <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      fdat_q[0]   <= '0;
      fdat_q[1]   <= '0;
      flast_q     <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fcnt_q      <= '0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      bank_q      <= bank_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      fdat_q      <= fdat_d;
      flast_q     <= flast_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fcnt_q      <= fcnt_d;
      busy_q      <= busy_d;
      finish_q    <= finish_d;
    end
  end

endmodule

// File: tb/tb_omem_readback.sv
// Directed bench for omem_readback: a THEIA output-memory model returning
// {bank,word} one cycle after each address, plus a host stream checker.
module tb_omem_readback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [17:0] count;
  logic        done;
  logic        busy;
  logic        finish;

  int n_checks = 0;
  int n_errors = 0;

  omem_readback_if #(.WB_WIDTH(32), .CORE_BITS(2)) bus ();

  omem_readback #(.WB_WIDTH(32), .CORE_BITS(2), .CNT_W(18)) dut (
    .CLK_I    (clk),
    .RST_I    (rst_n),
    .START_I  (start),
    .COUNT_I  (count),
    .DONE_I   (done),
    .BUSY_O   (busy),
    .FINISH_O (finish),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Output memory model: bank b word w holds {b,w}, valid one cycle after the address.
  always @(posedge clk) bus.OMEM_I <= {14'd0, bus.OMBSEL_O, bus.OMADR_O[15:0]};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts a job at the current negedge (cycle 0) and follows it to one cycle past FINISH.
  task automatic run_stream(input int cnt, input int done_at, input bit rand_rdy,
                            input bit inject, input int budget,
                            output int first_vld, output int fin_cyc);
    int          n_words;
    int          idx;
    int          n_fin;
    int          lin;
    bit          rdy;
    bit          held;
    logic [31:0] held_dat;
    logic [31:0] e;
    n_words   = 4 * cnt;
    idx       = 0;
    n_fin     = 0;
    first_vld = -1;
    fin_cyc   = -1;
    held      = 1'b0;
    held_dat  = '0;
    count     = 18'(cnt);
    done      = (done_at <= 0);
    start     = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (n_fin > 0 && c == fin_cyc + 1) begin
        check("idle_after_finish", busy, 0);
        check("no_vld_after_finish", bus.VLD_O, 0);
        break;
      end
      if (held) begin
        check("hold_vld", bus.VLD_O, 1);
        check("hold_dat", bus.DAT_O, held_dat);
      end
      if (bus.VLD_O && first_vld < 0) first_vld = c;
      if (c <= done_at + 1) begin
        check("wait_addr", {bus.OMBSEL_O, bus.OMADR_O}, 0);
        check("wait_vld", bus.VLD_O, 0);
      end
      if (cnt >= 2 && c == done_at + 2) check("first_issue_addr", bus.OMADR_O, 1);
      if (cnt > 0) begin
        lin = int'(bus.OMBSEL_O) * cnt + int'(bus.OMADR_O);
        check("addr_ahead", (lin <= idx + 2), 1);
      end
      rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.RDY_I = rdy;
      if (bus.VLD_O && rdy) begin
        e = (32'(idx / cnt) << 16) | 32'(idx % cnt);
        check("data", bus.DAT_O, e);
        check("last", bus.LAST_O, (idx == n_words - 1));
        idx++;
      end
      held     = bus.VLD_O && !rdy;
      held_dat = bus.DAT_O;
      if (finish) begin
        n_fin++;
        if (fin_cyc < 0) fin_cyc = c;
      end
      done  = (c >= done_at);
      start = inject && (c == 6);
      count = (inject && c == 6) ? 18'd7 : 18'(cnt);
    end
    check("word_count", idx, n_words);
    check("finish_pulses", n_fin, 1);
    start     = 1'b0;
    bus.RDY_I = 1'b1;
  endtask

  initial begin
    int fv;
    int fc;
    int got;
    int nf;
    rst_n     = 1'b0;
    start     = 1'b0;
    count     = '0;
    done      = 1'b0;
    bus.RDY_I = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_vld", bus.VLD_O, 0);
    check("rst_last", bus.LAST_O, 0);
    check("rst_busy", busy, 0);
    check("rst_finish", finish, 0);
    check("rst_bsel", bus.OMBSEL_O, 0);
    check("rst_adr", bus.OMADR_O, 0);
    check("rst_dat", bus.DAT_O, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic readback: 12 words, final word at cycle 15, FINISH at 16.
    run_stream(3, 1, 1'b0, 1'b0, 200, fv, fc);
    check("basic_first_vld", fv, 4);
    check("basic_finish_cyc", fc, 16);

    // Random back-pressure over 20 words.
    run_stream(5, 1, 1'b1, 1'b0, 400, fv, fc);

    // DONE held low for 10 cycles after START.
    run_stream(3, 11, 1'b0, 1'b0, 200, fv, fc);
    check("wait_first_vld", fv, 14);
    check("wait_finish_cyc", fc, 26);

    // Zero count: no words, FINISH two cycles after START.
    run_stream(0, 1, 1'b0, 1'b0, 50, fv, fc);
    check("zero_no_vld", fv, -1);
    check("zero_finish_cyc", fc, 2);

    // START with a different count during READ is ignored.
    run_stream(3, 1, 1'b0, 1'b1, 200, fv, fc);
    check("busy_start_finish_cyc", fc, 16);

    // Reset after 6 of 12 words.
    count = 18'd3;
    done  = 1'b1;
    start = 1'b1;
    got   = 0;
    for (int c = 1; c <= 50 && got < 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.VLD_O && bus.RDY_I) got++;
    end
    check("mid_words_before_reset", got, 6);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_vld", bus.VLD_O, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_finish", finish, 0);
    check("mid_rst_addr", {bus.OMBSEL_O, bus.OMADR_O}, 0);
    nf = 0;
    repeat (6) begin
      @(negedge clk);
      if (finish || bus.VLD_O) nf++;
    end
    check("mid_rst_quiet", nf, 0);
    run_stream(3, 1, 1'b0, 1'b0, 200, fv, fc);
    check("restart_first_vld", fv, 4);
    check("restart_finish_cyc", fc, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
